mailbox_irq_arbiter: RTL and testbench

Interrupt arbiter downstream of the mailbox unit. It consumes the per-mailbox `rcv_irq` and `snd_irq` level lines, latches them into per-source pending state, and picks one pending source at a time with round-robin order. It presents that source to a single core as one level interrupt plus a source ID, and tracks a claim/complete handshake so that each source is served exactly once per assertion.

---
 rtl/mailbox_irq_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mailbox_irq_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mailbox_irq_arbiter.sv
// ============================================================================
// Module   : mailbox_irq_arbiter
// Function : Round-robin interrupt arbiter with a claim/complete handshake
//            for per-mailbox receive and send interrupt levels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mailbox_irq_arbiter #(
  parameter int NumMbox = 4,
  parameter int IdWidth = (NumMbox > 1) ? $clog2(NumMbox) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumMbox-1:0] rcv_irq_i,
  input  logic [NumMbox-1:0] snd_irq_i,
  output logic               irq_o,
  output logic [IdWidth-1:0] irq_id_o,
  output logic               irq_snd_o,
  input  logic               claim_i,
  input  logic               complete_i,
  input  logic [IdWidth-1:0] complete_id_i,
  input  logic               complete_snd_i,
  output logic               err_o
);

  localparam int c_NUM_SRC = 2 * NumMbox;
  localparam int c_SRC_W   = $clog2(c_NUM_SRC);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_NOTIFY = 2'd1,
    ST_BUSY   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_CLMD = 2'd2
  } gw_e;

  state_e               r_state;
  logic [c_SRC_W-1:0]   r_rr;
  logic [c_SRC_W-1:0]   r_sel;
  logic                 r_irq;
  logic [IdWidth-1:0]   r_irq_id;
  logic                 r_irq_snd;
  logic                 r_err;

  logic [c_NUM_SRC-1:0] w_src;
  logic [c_NUM_SRC-1:0] w_pend;
  logic [c_NUM_SRC-1:0] w_req;
  logic                 w_found;
  logic [c_SRC_W-1:0]   w_win;
  logic [IdWidth-1:0]   w_win_id;
  logic                 w_win_snd;
  logic [c_SRC_W-1:0]   w_rr_next;
  logic                 w_id_ok;
  logic                 w_cmp_match;
  logic                 w_claim_ok;
  logic                 w_cmp_ok;
  logic                 w_withdraw;
  logic                 w_err;

  assign w_src = {snd_irq_i, rcv_irq_i};
  // A pending source whose level already fell is about to go idle; skip it.
  assign w_req = w_pend & w_src;

  genvar s;
  generate
    for (s = 0; s < c_NUM_SRC; s++) begin : g_gw
      gw_e r_gw;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_gw <= GW_IDLE;
        end else begin
          case (r_gw)
            GW_IDLE: if (w_src[s]) r_gw <= GW_PEND;
            GW_PEND: begin
              if (w_claim_ok && (r_sel == c_SRC_W'(s))) r_gw <= GW_CLMD;
              else if (!w_src[s])                       r_gw <= GW_IDLE;
            end
            GW_CLMD: if (w_cmp_ok && (r_sel == c_SRC_W'(s))) r_gw <= GW_IDLE;
            default: r_gw <= GW_IDLE;
          endcase
        end
      end
      assign w_pend[s] = (r_gw == GW_PEND);
    end
  endgenerate

  always_comb begin
    int unsigned v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < c_NUM_SRC; k++) begin
      v_idx = int'(r_rr) + k;
      if (v_idx >= c_NUM_SRC) v_idx = v_idx - c_NUM_SRC;
      if (!w_found && w_req[c_SRC_W'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = c_SRC_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_win_snd = (int'(w_win) >= NumMbox);
    w_win_id  = IdWidth'(int'(w_win) - (w_win_snd ? NumMbox : 0));
  end

  assign w_rr_next = (r_sel == c_SRC_W'(c_NUM_SRC - 1)) ? '0 : r_sel + 1'b1;

  assign w_id_ok     = (int'(complete_id_i) < NumMbox);
  assign w_cmp_match = w_id_ok &&
                       ((int'(complete_id_i) + (complete_snd_i ? NumMbox : 0)) == int'(r_sel));

  assign w_claim_ok = claim_i && (r_state == ST_NOTIFY);
  assign w_cmp_ok   = complete_i && (r_state == ST_BUSY) && w_cmp_match;
  assign w_withdraw = (r_state == ST_NOTIFY) && !claim_i && !w_src[r_sel];
  assign w_err      = (claim_i && (r_state != ST_NOTIFY)) ||
                      (complete_i && ((r_state != ST_BUSY) || !w_cmp_match));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_ARB;
      r_rr      <= '0;
      r_sel     <= '0;
      r_irq     <= 1'b0;
      r_irq_id  <= '0;
      r_irq_snd <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_err;
      case (r_state)
        ST_ARB: begin
          if (w_found) begin
            r_sel     <= w_win;
            r_irq     <= 1'b1;
            r_irq_id  <= w_win_id;
            r_irq_snd <= w_win_snd;
            r_state   <= ST_NOTIFY;
          end
        end
        ST_NOTIFY: begin
          if (claim_i) begin
            r_irq   <= 1'b0;
            r_rr    <= w_rr_next;
            r_state <= ST_BUSY;
          end else if (w_withdraw) begin
            r_irq   <= 1'b0;
            r_state <= ST_ARB;
          end
        end
        ST_BUSY: begin
          if (w_cmp_ok) r_state <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign irq_o     = r_irq;
  assign irq_id_o  = r_irq_id;
  assign irq_snd_o = r_irq_snd;
  assign err_o     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mailbox_irq_arbiter.sv
// ============================================================================
// Module   : tb_mailbox_irq_arbiter
// Function : Directed vector bench for mailbox_irq_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mailbox_irq_arbiter;

  typedef struct {
    logic [3:0] rcv;
    logic [3:0] snd;
    logic       clm;
    logic       cmp;
    logic [1:0] cid;
    logic       csnd;
    logic       irq;
    logic [1:0] id;
    logic       isnd;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  logic       clk;
  logic       rst_ni;
  logic [3:0] rcv, snd;
  logic       clm, cmp, csnd;
  logic [1:0] cid;
  logic       irq, isnd, err;
  logic [1:0] id;

  logic [4:0] rcv2, snd2;
  logic       clm2, cmp2, csnd2;
  logic [2:0] cid2;
  logic       irq2, isnd2, err2;
  logic [2:0] id2;

  int n_chk = 0;
  int n_err = 0;

  mailbox_irq_arbiter #(.NumMbox(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rcv_irq_i(rcv), .snd_irq_i(snd),
    .irq_o(irq), .irq_id_o(id), .irq_snd_o(isnd),
    .claim_i(clm), .complete_i(cmp),
    .complete_id_i(cid), .complete_snd_i(csnd),
    .err_o(err)
  );

  // Five mailboxes so that an out-of-range completion index is encodable.
  mailbox_irq_arbiter #(.NumMbox(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_ni),
    .rcv_irq_i(rcv2), .snd_irq_i(snd2),
    .irq_o(irq2), .irq_id_o(id2), .irq_snd_o(isnd2),
    .claim_i(clm2), .complete_i(cmp2),
    .complete_id_i(cid2), .complete_snd_i(csnd2),
    .err_o(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic v(input logic [3:0] r, input logic [3:0] s, input logic c,
                   input logic m, input logic [1:0] ci, input logic cs,
                   input logic ei, input logic [1:0] eid, input logic es, input logic ee);
    vecs.push_back('{r, s, c, m, ci, cs, ei, eid, es, ee});
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {irq,id,snd,err}=%h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    //  rcv      snd      clm cmp cid csnd | irq id snd err
    v(4'b1001, 4'b0010, 0, 0, 0, 0,  0, 0, 0, 0); // r0  round robin
    v(4'b1001, 4'b0010, 0, 0, 0, 0,  1, 0, 0, 0);
    v(4'b1001, 4'b0010, 1, 0, 0, 0,  0, 0, 0, 0);
    v(4'b1000, 4'b0010, 0, 1, 0, 0,  0, 0, 0, 0);
    v(4'b1000, 4'b0010, 0, 0, 0, 0,  1, 3, 0, 0);
    v(4'b1000, 4'b0010, 1, 0, 0, 0,  0, 3, 0, 0);
    v(4'b0000, 4'b0010, 0, 1, 3, 0,  0, 3, 0, 0);
    v(4'b0000, 4'b0010, 0, 0, 0, 0,  1, 1, 1, 0);
    v(4'b0000, 4'b0010, 1, 0, 0, 0,  0, 1, 1, 0);
    v(4'b0000, 4'b0000, 0, 1, 1, 1,  0, 1, 1, 0);
    v(4'b0001, 4'b1000, 0, 0, 0, 0,  0, 1, 1, 0); // r10 s0+s7 with rr=6
    v(4'b0001, 4'b1000, 0, 0, 0, 0,  1, 3, 1, 0);
    v(4'b0001, 4'b1000, 1, 0, 0, 0,  0, 3, 1, 0);
    v(4'b0001, 4'b0000, 0, 1, 3, 1,  0, 3, 1, 0);
    v(4'b0001, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 0);
    v(4'b0001, 4'b0000, 1, 0, 0, 0,  0, 0, 0, 0);
    v(4'b0001, 4'b0000, 0, 1, 1, 1,  0, 0, 0, 1); // r16 mismatched complete
    v(4'b0001, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0);
    v(4'b0000, 4'b0000, 0, 1, 0, 0,  0, 0, 0, 0);
    v(4'b0000, 4'b0000, 1, 0, 0, 0,  0, 0, 0, 1); // r19 claim in ARB
    v(4'b0000, 4'b0000, 0, 1, 2, 0,  0, 0, 0, 1); // r20 complete in ARB
    v(4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0);
    v(4'b0100, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0); // r22 single source
    v(4'b0100, 4'b0000, 0, 0, 0, 0,  1, 2, 0, 0);
    v(4'b0100, 4'b0000, 0, 0, 0, 0,  1, 2, 0, 0);
    v(4'b0100, 4'b0000, 1, 0, 0, 0,  0, 2, 0, 0);
    v(4'b0000, 4'b0000, 0, 1, 2, 0,  0, 2, 0, 0);
    v(4'b0000, 4'b0000, 0, 0, 0, 0,  0, 2, 0, 0);
    v(4'b0000, 4'b0000, 0, 0, 0, 0,  0, 2, 0, 0);
    v(4'b0000, 4'b0010, 0, 0, 0, 0,  0, 2, 0, 0); // r29 withdraw
    v(4'b0000, 4'b0010, 0, 0, 0, 0,  1, 1, 1, 0);
    v(4'b0000, 4'b0000, 0, 0, 0, 0,  0, 1, 1, 0);
    v(4'b0000, 4'b0000, 1, 0, 0, 0,  0, 1, 1, 1);
    v(4'b0000, 4'b0000, 0, 0, 0, 0,  0, 1, 1, 0);
    v(4'b0100, 4'b0001, 0, 0, 0, 0,  0, 1, 1, 0); // r34 rr still 3: s4 before s2
    v(4'b0100, 4'b0001, 0, 0, 0, 0,  1, 0, 1, 0);
    v(4'b0100, 4'b0001, 1, 0, 0, 0,  0, 0, 1, 0);
    v(4'b0100, 4'b0000, 0, 1, 0, 1,  0, 0, 1, 0);
    v(4'b0100, 4'b0000, 0, 0, 0, 0,  1, 2, 0, 0);
    v(4'b0100, 4'b0000, 1, 0, 0, 0,  0, 2, 0, 0); // r39 level held through complete
    v(4'b0100, 4'b0000, 0, 1, 2, 0,  0, 2, 0, 0);
    v(4'b0100, 4'b0000, 0, 0, 0, 0,  0, 2, 0, 0);
    v(4'b0100, 4'b0000, 0, 0, 0, 0,  1, 2, 0, 0);
    v(4'b0100, 4'b0000, 1, 0, 0, 0,  0, 2, 0, 0);

    rcv = '0; snd = '0; clm = 0; cmp = 0; cid = '0; csnd = 0;
    rcv2 = '0; snd2 = '0; clm2 = 0; cmp2 = 0; cid2 = '0; csnd2 = 0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset", {3'b0, irq, id, isnd, err}, 8'h00);
    chk("reset_n5", {2'b0, irq2, id2, isnd2, err2}, 8'h00);
    @(negedge clk) rst_ni = 1'b1;

    foreach (vecs[i]) begin
      rcv = vecs[i].rcv; snd = vecs[i].snd; clm = vecs[i].clm;
      cmp = vecs[i].cmp; cid = vecs[i].cid; csnd = vecs[i].csnd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {3'b0, irq, id, isnd, err},
          {3'b0, vecs[i].irq, vecs[i].id, vecs[i].isnd, vecs[i].err});
      @(negedge clk);
    end

    // Asynchronous reset while a claim is outstanding.
    rcv = 4'b0100; snd = 4'b0001; clm = 0; cmp = 0;
    #1 rst_ni = 1'b0;
    #1 chk("rst_async", {3'b0, irq, id, isnd, err}, 8'h00);
    @(posedge clk); #1 chk("rst_hold", {3'b0, irq, id, isnd, err}, 8'h00);
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1 chk("rst_rel1", {3'b0, irq, id, isnd, err}, 8'h00);
    @(posedge clk); #1 chk("rst_rel2", {3'b0, irq, id, isnd, err}, {3'b0, 1'b1, 2'd2, 1'b0, 1'b0});

    // Completion index beyond the mailbox count, five-mailbox instance.
    @(negedge clk) rcv2 = 5'b10000;
    @(posedge clk); #1 chk("n5_pend", {2'b0, irq2, id2, isnd2, err2}, 8'h00);
    @(posedge clk); #1 chk("n5_irq", {2'b0, irq2, id2, isnd2, err2}, {2'b0, 1'b1, 3'd4, 1'b0, 1'b0});
    @(negedge clk) clm2 = 1;
    @(posedge clk); #1 chk("n5_claim", {2'b0, irq2, id2, isnd2, err2}, {2'b0, 1'b0, 3'd4, 1'b0, 1'b0});
    @(negedge clk) begin clm2 = 0; cmp2 = 1; cid2 = 3'd5; csnd2 = 0; end
    @(posedge clk); #1 chk("n5_badid", {2'b0, irq2, id2, isnd2, err2}, {2'b0, 1'b0, 3'd4, 1'b0, 1'b1});
    @(negedge clk) begin cid2 = 3'd4; rcv2 = '0; end
    @(posedge clk); #1 chk("n5_cmp", {2'b0, irq2, id2, isnd2, err2}, {2'b0, 1'b0, 3'd4, 1'b0, 1'b0});
    @(negedge clk) begin cmp2 = 0; snd2 = 5'b00001; end
    @(posedge clk); #1 chk("n5_pend2", {2'b0, irq2, id2, isnd2, err2}, {2'b0, 1'b0, 3'd4, 1'b0, 1'b0});
    @(posedge clk); #1 chk("n5_irq2", {2'b0, irq2, id2, isnd2, err2}, {2'b0, 1'b1, 3'd0, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
